dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory between the CPU memory stage (port 0) and a DMA/program-loader port (port 1). Each cycle it grants at most one valid/ready request, drives the memory write enable, address and write data, and returns a registered one-cycle response to the granted requester. Round-robin fairness applies, plus an optional bounded lock for multi-beat bursts. It sits between the requesters and `data_mem`; the result mux in the memory stage consumes `rsp0_rdata`.

---
 rtl/mem_pkg.sv | 13 +
 rtl/dmem_arbiter_if.sv | 24 ++
 rtl/rr_arbiter2.sv | 15 +
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and port indices for the data-memory arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester channel of the data-memory arbiter: request handshake plus registered response.
// Handshake: a beat transfers in the cycle where valid && ready; the requester holds valid and payload until then.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  we;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  lock;
    logic                  ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output valid, we, addr, wdata, lock,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata, lock,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-input combinational round-robin grant; ptr_i names the preferred port on contention.
module rr_arbiter2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and DMA (port 1) with
// round-robin fairness, bounded burst locking and a registered one-cycle response.
module dmem_arbiter
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 4,
    localparam int CNT_W     = $clog2(LOCK_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_arbiter_if.slave         req0,
    dmem_arbiter_if.slave         req1,
    output logic                  mem_wr_en,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output arb_state_t            dbg_state_o,
    output logic                  dbg_rr_ptr_o,
    output logic [CNT_W-1:0]      dbg_beat_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    arb_state_t            state_q, state_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d, cnt_inc;
    logic [1:0]            valid, lock, we, idle_gnt, gnt;
    logic [1:0]            rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;

    assign valid = {req1.valid, req0.valid};
    assign lock  = {req1.lock,  req0.lock};
    assign we    = {req1.we,    req0.we};

    rr_arbiter2 u_rr (
        .valid_i (valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (idle_gnt)
    );

    assign cnt_inc = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : beat_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        gnt        = 2'b00;
        unique case (state_q)
            IDLE: begin
                gnt        = idle_gnt;
                beat_cnt_d = '0;
                if (gnt != 2'b00) begin
                    rr_ptr_d = gnt[PORT_CPU];
                    // A single-beat limit makes locking meaningless, so never enter a lock state.
                    if (((gnt & lock) != 2'b00) && (LOCK_MAX > 1)) begin
                        state_d    = gnt[PORT_CPU] ? LOCK0 : LOCK1;
                        beat_cnt_d = CNT_W'(1);
                    end
                end
            end
            LOCK0: begin
                gnt[PORT_CPU] = valid[PORT_CPU];
                if (valid[PORT_CPU]) begin
                    beat_cnt_d = cnt_inc;
                    rr_ptr_d   = 1'b1;
                    if (!lock[PORT_CPU] || cnt_inc == CNT_MAX) state_d = IDLE;
                end else begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end
            end
            LOCK1: begin
                gnt[PORT_DMA] = valid[PORT_DMA];
                if (valid[PORT_DMA]) begin
                    beat_cnt_d = cnt_inc;
                    rr_ptr_d   = 1'b0;
                    if (!lock[PORT_DMA] || cnt_inc == CNT_MAX) state_d = IDLE;
                end else begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) gnt = 2'b00;
    end

    always_comb begin
        mem_wr_en = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[PORT_CPU]) begin
            mem_wr_en = req0.we;
            mem_addr  = req0.addr;
            mem_wdata = req0.wdata;
        end else if (gnt[PORT_DMA]) begin
            mem_wr_en = req1.we;
            mem_addr  = req1.addr;
            mem_wdata = req1.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            beat_cnt_q   <= '0;
            rsp_valid_q  <= 2'b00;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            rsp_valid_q <= gnt;
            if (gnt[PORT_CPU]) rsp0_rdata_q <= we[PORT_CPU] ? '0 : mem_rdata;
            if (gnt[PORT_DMA]) rsp1_rdata_q <= we[PORT_DMA] ? '0 : mem_rdata;
        end
    end

    assign req0.ready     = gnt[PORT_CPU];
    assign req1.ready     = gnt[PORT_DMA];
    assign req0.rsp_valid = rsp_valid_q[PORT_CPU];
    assign req1.rsp_valid = rsp_valid_q[PORT_DMA];
    assign req0.rsp_rdata = rsp0_rdata_q;
    assign req1.rsp_rdata = rsp1_rdata_q;

    assign dbg_state_o    = state_q;
    assign dbg_rr_ptr_o   = rr_ptr_q;
    assign dbg_beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: the driver pushes expected responses, a monitor pops them.
module tb_dmem_arbiter;
    import mem_pkg::*;

    localparam int DW = 32;
    localparam int LM = 4;

    logic          clk;
    logic          rst;
    logic          mem_wr_en;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    arb_state_t    dbg_state;
    logic          dbg_rr_ptr;
    logic [2:0]    dbg_beat_cnt;

    dmem_arbiter_if #(.DATA_WIDTH(DW)) req0_if ();
    dmem_arbiter_if #(.DATA_WIDTH(DW)) req1_if ();

    dmem_arbiter #(.DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
        .clk            (clk),
        .rst            (rst),
        .req0           (req0_if),
        .req1           (req1_if),
        .mem_wr_en      (mem_wr_en),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .dbg_state_o    (dbg_state),
        .dbg_rr_ptr_o   (dbg_rr_ptr),
        .dbg_beat_cnt_o (dbg_beat_cnt)
    );

    // Clock / reset, plus a small word-addressed memory standing in for data_mem.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [DW-1:0] mem [0:63];
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (rst) mem[4] <= 32'hDEADBEEF;
        else if (mem_wr_en) mem[mem_addr[7:2]] <= mem_wdata;
    end

    // Scoreboard state.
    logic [DW-1:0] exp0_q[$], exp1_q[$];
    int            due0_q[$], due1_q[$];
    int            tests_run    = 0;
    int            tests_failed = 0;
    int            cycle_cnt    = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int p, input logic v, input logic [DW-1:0] rd);
        logic [DW-1:0] e;
        int            due;
        int            n;
        n = (p == 0) ? exp0_q.size() : exp1_q.size();
        if (v === 1'b1) begin
            if (n == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rsp%0d unexpected: got rdata %h, expected no response", p, rd);
            end else begin
                if (p == 0) begin e = exp0_q.pop_front(); due = due0_q.pop_front(); end
                else        begin e = exp1_q.pop_front(); due = due1_q.pop_front(); end
                check($sformatf("rsp%0d_rdata", p), rd, e);
                check($sformatf("rsp%0d latency", p), cycle_cnt, due);
            end
        end else if (n != 0) begin
            due = (p == 0) ? due0_q[0] : due1_q[0];
            if (due <= cycle_cnt) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rsp%0d missing: got no response in cycle %0d, expected one", p, cycle_cnt);
                if (p == 0) begin void'(exp0_q.pop_front()); void'(due0_q.pop_front()); end
                else        begin void'(exp1_q.pop_front()); void'(due1_q.pop_front()); end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, req0_if.rsp_valid, req0_if.rsp_rdata);
        mon(1, req1_if.rsp_valid, req1_if.rsp_rdata);
    end

    // Driver tasks.
    task automatic drv0(input logic v, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d, input logic lk);
        req0_if.valid = v; req0_if.we = we; req0_if.addr = a; req0_if.wdata = d; req0_if.lock = lk;
    endtask

    task automatic drv1(input logic v, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d, input logic lk);
        req1_if.valid = v; req1_if.we = we; req1_if.addr = a; req1_if.wdata = d; req1_if.lock = lk;
    endtask

    // One clock cycle: check grant/state/memory bus mid-cycle, queue the expected response.
    task automatic cyc(input string tag, input logic [1:0] gnt, input arb_state_t st, input logic [DW-1:0] rdata);
        @(negedge clk);
        check({tag, " ready"}, {30'b0, req1_if.ready, req0_if.ready}, {30'b0, gnt});
        check({tag, " state"}, 32'(dbg_state), 32'(st));
        if (gnt == 2'b01) begin
            check({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'(req0_if.we));
            check({tag, " mem_addr"}, mem_addr, req0_if.addr);
            check({tag, " mem_wdata"}, mem_wdata, req0_if.wdata);
            exp0_q.push_back(rdata);
            due0_q.push_back(cycle_cnt + 1);
        end else if (gnt == 2'b10) begin
            check({tag, " mem_wr_en"}, 32'(mem_wr_en), 32'(req1_if.we));
            check({tag, " mem_addr"}, mem_addr, req1_if.addr);
            check({tag, " mem_wdata"}, mem_wdata, req1_if.wdata);
            exp1_q.push_back(rdata);
            due1_q.push_back(cycle_cnt + 1);
        end else begin
            check({tag, " idle mem_wr_en"}, 32'(mem_wr_en), 32'd0);
            check({tag, " idle mem_addr"}, mem_addr, 32'd0);
            check({tag, " idle mem_wdata"}, mem_wdata, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drv0(0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", {30'b0, req1_if.ready, req0_if.ready}, 32'd0);
        check("reset rsp_valid", {30'b0, req1_if.rsp_valid, req0_if.rsp_valid}, 32'd0);
        check("reset rsp0_rdata", req0_if.rsp_rdata, 32'd0);
        check("reset rsp1_rdata", req1_if.rsp_rdata, 32'd0);
        check("reset mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("reset state", 32'(dbg_state), 32'(IDLE));
        check("reset rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        check("reset beat_cnt", 32'(dbg_beat_cnt), 32'd0);
        rst = 1'b0;

        // CPU-only load, then store/load round trip.
        drv0(1, 0, 32'h10, 0, 0);                    cyc("cpu_ld", 2'b01, IDLE, 32'hDEADBEEF);
        drv0(1, 1, 32'h20, 32'h12345678, 0);         cyc("st", 2'b01, IDLE, 32'h0);
        drv0(1, 0, 32'h20, 0, 0);                    cyc("ld_back", 2'b01, IDLE, 32'h12345678);
        drv0(0, 0, 0, 0, 0);
        drv1(1, 0, 32'h10, 0, 0);                    cyc("dma_ld", 2'b10, IDLE, 32'hDEADBEEF);

        // Contention: both store every cycle, each holding its beat until accepted.
        drv0(1, 1, 32'h40, 32'hA0A00000, 0);
        drv1(1, 1, 32'h80, 32'hB0B00000, 0);         cyc("cont1", 2'b01, IDLE, 32'h0);
        drv0(1, 1, 32'h44, 32'hA1A10001, 0);         cyc("cont2", 2'b10, IDLE, 32'h0);
        drv1(1, 1, 32'h84, 32'hB1B10001, 0);         cyc("cont3", 2'b01, IDLE, 32'h0);
        drv0(1, 1, 32'h48, 32'hA2A20002, 0);         cyc("cont4", 2'b10, IDLE, 32'h0);
        drv1(0, 0, 0, 0, 0);                         cyc("cont5", 2'b01, IDLE, 32'h0);
        drv0(0, 0, 0, 0, 0);                         cyc("cont_idle", 2'b00, IDLE, 32'h0);
        drv0(1, 0, 32'h40, 0, 0);                    cyc("rd40", 2'b01, IDLE, 32'hA0A00000);
        drv0(1, 0, 32'h44, 0, 0);                    cyc("rd44", 2'b01, IDLE, 32'hA1A10001);
        drv0(1, 0, 32'h48, 0, 0);                    cyc("rd48", 2'b01, IDLE, 32'hA2A20002);
        drv0(0, 0, 0, 0, 0);
        drv1(1, 0, 32'h80, 0, 0);                    cyc("rd80", 2'b10, IDLE, 32'hB0B00000);
        drv1(1, 0, 32'h84, 0, 0);                    cyc("rd84", 2'b10, IDLE, 32'hB1B10001);

        // Locked burst of 6 beats against a persistent CPU request, LOCK_MAX = 4.
        drv1(1, 0, 32'h80, 0, 1);                    cyc("burst1", 2'b10, IDLE, 32'hB0B00000);
        drv0(1, 0, 32'h40, 0, 0);
        drv1(1, 0, 32'h84, 0, 1);                    cyc("burst2", 2'b10, LOCK1, 32'hB1B10001);
        drv1(1, 0, 32'h80, 0, 1);                    cyc("burst3", 2'b10, LOCK1, 32'hB0B00000);
        drv1(1, 0, 32'h84, 0, 1);                    cyc("burst4", 2'b10, LOCK1, 32'hB1B10001);
        drv1(1, 0, 32'h80, 0, 1);                    cyc("forced_rel", 2'b01, IDLE, 32'hA0A00000);
        drv0(1, 0, 32'h44, 0, 0);                    cyc("burst5", 2'b10, IDLE, 32'hB0B00000);
        drv1(1, 0, 32'h84, 0, 0);                    cyc("burst6", 2'b10, LOCK1, 32'hB1B10001);
        drv1(0, 0, 0, 0, 0);                         cyc("cpu_after", 2'b01, IDLE, 32'hA1A10001);

        // Lock drop: requester deasserts valid while still holding the lock.
        drv0(0, 0, 0, 0, 0);
        drv1(1, 0, 32'h80, 0, 1);                    cyc("drop1", 2'b10, IDLE, 32'hB0B00000);
        drv0(1, 0, 32'h48, 0, 0);
        drv1(1, 0, 32'h84, 0, 1);                    cyc("drop2", 2'b10, LOCK1, 32'hB1B10001);
        drv1(0, 0, 0, 0, 0);                         cyc("drop_gap", 2'b00, LOCK1, 32'h0);
        cyc("drop_cpu", 2'b01, IDLE, 32'hA2A20002);

        // Reset in the cycle after an accepted load.
        drv0(1, 0, 32'h10, 0, 0);                    cyc("pre_rst", 2'b01, IDLE, 32'hDEADBEEF);
        rst = 1'b1;
        drv0(1, 0, 32'h20, 0, 0);
        drv1(1, 0, 32'h10, 0, 0);
        @(negedge clk);
        check("rst ready gated", {30'b0, req1_if.ready, req0_if.ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst rsp_valid", {30'b0, req1_if.rsp_valid, req0_if.rsp_valid}, 32'd0);
        check("post_rst state", 32'(dbg_state), 32'(IDLE));
        check("post_rst rr_ptr", 32'(dbg_rr_ptr), 32'd0);
        check("post_rst beat_cnt", 32'(dbg_beat_cnt), 32'd0);
        cyc("post_rst p0", 2'b01, IDLE, 32'h12345678);
        drv0(0, 0, 0, 0, 0);                         cyc("post_rst p1", 2'b10, IDLE, 32'hDEADBEEF);
        drv1(0, 0, 0, 0, 0);                         cyc("tail", 2'b00, IDLE, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("exp0 drained", exp0_q.size(), 32'd0);
        check("exp1 drained", exp1_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
